// File: rtl/stepper_seq.sv
// -----------------------------------------------------------------------------
// stepper_seq -- stepper motor phase sequencer
//
// Steps an 8-entry coil pattern table (half-step granularity) forward or in
// reverse, in full-step (phase +/-2) or half-step (phase +/-1) mode. Each step
// takes STEP_PERIOD clock cycles. A move can be paused (level) or aborted.
//
// Optional feature macro: STEPPER_SEQ_HOLD_EN
//   defined   : coils stay energized with pattern[p] while idle (holding torque)
//   undefined : coils are de-energized (0000) while idle
//
// Parameters
//   STEP_PERIOD  clock cycles per motor step (>= 2)
//   CNT_W        width of the step-count request / remaining-count output
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst_n         asynchronous active-low reset
//   start_i       move request, sampled only while idle
//   dir_i         1 = forward (phase +), 0 = reverse; latched at start
//   half_i        1 = half-step, 0 = full-step; latched at start
//   steps_i       number of steps; latched at start
//   pause_i       level, freezes an active move
//   abort_i       terminates an active move (no done pulse)
//   busy_o        high while a move is running or paused
//   done_o        one-cycle pulse on normal completion
//   steps_left_o  remaining steps
//   phase_o       current phase index p (0..7)
//   signal_o      coil drive pattern
// -----------------------------------------------------------------------------
module stepper_seq #(
  parameter int unsigned STEP_PERIOD = 10000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             dir_i,
  input  logic             half_i,
  input  logic [CNT_W-1:0] steps_i,
  input  logic             pause_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] steps_left_o,
  output logic [2:0]       phase_o,
  output logic [3:0]       signal_o
);

  localparam int unsigned      TMR_W    = (STEP_PERIOD > 2) ? $clog2(STEP_PERIOD) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       phase_q, phase_d;
  logic             dir_q, dir_d;
  logic             half_q, half_d;
  logic             done_q, done_d;
  logic [2:0]       step_s;
  logic             busy_s;

  // Coil pattern for each half-step phase index.
  function automatic logic [3:0] pattern_f(input logic [2:0] p);
    logic [3:0] pat;
    case (p)
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      3'd7:    pat = 4'b1001;
      default: pat = 4'b0000;
    endcase
    return pat;
  endfunction

  // Signed phase increment as a modulo-8 addend (-1 = 7, -2 = 6).
  always_comb begin
    step_s = 3'd0;
    if (dir_q) begin
      step_s = half_q ? 3'd1 : 3'd2;
    end else begin
      step_s = half_q ? 3'd7 : 3'd6;
    end
  end

  // Next-state logic for the move FSM, timer, step counter and phase.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    dir_d   = dir_q;
    half_d  = half_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (steps_i != {CNT_W{1'b0}}) begin
            state_d = S_RUN;
            cnt_d   = steps_i;
            timer_d = {TMR_W{1'b0}};
            dir_d   = dir_i;
            half_d  = half_i;
          end else begin
            // Zero-length move completes at once without going busy.
            done_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN, S_PAUSE: begin
        if (abort_i) begin
          state_d = S_IDLE;
          cnt_d   = {CNT_W{1'b0}};
          timer_d = {TMR_W{1'b0}};
        end else if (pause_i) begin
          // Pause wins over a coinciding terminal count: nothing advances.
          state_d = S_PAUSE;
        end else begin
          // Releasing pause resumes counting in this same cycle, so the frozen
          // time equals exactly the number of cycles pause_i was high.
          state_d = S_RUN;
          if (timer_q == TMR_LAST) begin
            timer_d = {TMR_W{1'b0}};
            phase_d = phase_q + step_s;
            cnt_d   = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = {TMR_W{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= {TMR_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      phase_q <= 3'd0;
      dir_q   <= 1'b0;
      half_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      half_q  <= half_d;
      done_q  <= done_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    busy_s = (state_q != S_IDLE);
`ifdef STEPPER_SEQ_HOLD_EN
    signal_o = pattern_f(phase_q);
`else
    if (busy_s) begin
      signal_o = pattern_f(phase_q);
    end else begin
      signal_o = 4'b0000;
    end
`endif
  end

  assign busy_o       = busy_s;
  assign done_o       = done_q;
  assign steps_left_o = cnt_q;
  assign phase_o      = phase_q;

endmodule

// File: tb/tb_stepper_seq.sv
// -----------------------------------------------------------------------------
// tb_stepper_seq -- self-checking bench for stepper_seq (STEP_PERIOD=4).
// A behavioural model tracks the move as "steps remaining" plus "active cycles
// spent in the current step"; every cycle all outputs are compared with it.
// Honours STEPPER_SEQ_HOLD_EN for the idle coil pattern.
// -----------------------------------------------------------------------------
module tb_stepper_seq;

  localparam int SP    = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_i, dir_i, half_i, pause_i, abort_i;
  logic [CNT_W-1:0] steps_i;
  logic             busy_o, done_o;
  logic [CNT_W-1:0] steps_left_o;
  logic [2:0]       phase_o;
  logic [3:0]       signal_o;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cnt;

  // reference model state
  bit m_busy, m_done, m_dir, m_half;
  int m_left, m_el, m_phase;

  logic [3:0] pat [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                          4'b0010, 4'b0011, 4'b0001, 4'b1001};

  stepper_seq #(.STEP_PERIOD(SP), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .dir_i        (dir_i),
    .half_i       (half_i),
    .steps_i      (steps_i),
    .pause_i      (pause_i),
    .abort_i      (abort_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .steps_left_o (steps_left_o),
    .phase_o      (phase_o),
    .signal_o     (signal_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_signal();
`ifdef STEPPER_SEQ_HOLD_EN
    return pat[m_phase];
`else
    return m_busy ? pat[m_phase] : 4'b0000;
`endif
  endfunction

  task automatic check_all();
    check_val("busy",   {31'd0, busy_o}, {31'd0, m_busy});
    check_val("done",   {31'd0, done_o}, {31'd0, m_done});
    check_val("left",   {16'd0, steps_left_o}, 32'(m_left));
    check_val("phase",  {29'd0, phase_o}, 32'(m_phase));
    check_val("signal", {28'd0, signal_o}, {28'd0, exp_signal()});
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_el = 0; m_phase = 0;
    m_dir = 1'b0; m_half = 1'b0;
  endtask

  // One clock of the behavioural model, using the inputs seen at the edge.
  task automatic model_step();
    int delta;
    m_done = 1'b0;
    if (!m_busy) begin
      if (start_i) begin
        if (steps_i != 0) begin
          m_busy = 1'b1; m_left = int'(steps_i); m_el = 0;
          m_dir = dir_i; m_half = half_i;
        end else begin
          m_done = 1'b1;
        end
      end
    end else if (abort_i) begin
      m_busy = 1'b0; m_left = 0; m_el = 0;
    end else if (!pause_i) begin
      m_el++;
      if (m_el == SP) begin
        m_el = 0;
        m_left--;
        delta = (m_half ? 1 : 2) * (m_dir ? 1 : -1);
        m_phase = (m_phase + delta + 8) % 8;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  endtask

  // Drive inputs, clock once, advance the model, and compare all outputs.
  task automatic cycle(input bit st, input bit dr, input bit hf, input int n,
                       input bit ps, input bit ab);
    start_i = st; dir_i = dr; half_i = hf; steps_i = CNT_W'(n);
    pause_i = ps; abort_i = ab;
    @(posedge clk);
    model_step();
    #1;
    if (busy_o) busy_cnt++;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    start_i = 1'b0; dir_i = 1'b0; half_i = 1'b0; steps_i = '0;
    pause_i = 1'b0; abort_i = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #3;
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // 3 full steps forward from p=0: 1000, 0100, 0010 for 4 cycles each
    busy_cnt = 0;
    cycle(1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0);
    idle(14);
    check_val("busy_len_3x4", 32'(busy_cnt), 32'd12);
    check_val("phase_after_fwd", {29'd0, phase_o}, 32'd6);

    // 2 half steps reverse from p=6 -> 5 -> 4
    cycle(1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b0);
    idle(10);
    check_val("phase_after_rev", {29'd0, phase_o}, 32'd4);

    // 8-step move with a 10-cycle pause mid-step
    busy_cnt = 0;
    cycle(1'b1, 1'b1, 1'b0, 8, 1'b0, 1'b0);
    idle(5);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle(40);
    check_val("busy_len_pause", 32'(busy_cnt), 32'd42);

    // abort during the 2nd step of a 5-step move, then restart at once;
    // a start while busy (with other parameters) must be ignored
    cycle(1'b1, 1'b1, 1'b1, 5, 1'b0, 1'b0);
    idle(5);
    cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    check_val("abort_left", {16'd0, steps_left_o}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    check_val("restart_busy", {31'd0, busy_o}, 32'd1);
    cycle(1'b1, 1'b1, 1'b1, 7, 1'b0, 1'b0);
    idle(12);

    // zero-step start: done one cycle later, never busy
    cycle(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    check_val("zero_done", {31'd0, done_o}, 32'd1);
    check_val("zero_busy", {31'd0, busy_o}, 32'd0);
    idle(1);
    check_val("zero_done_clr", {31'd0, done_o}, 32'd0);

    // asynchronous reset in the middle of a move
    cycle(1'b1, 1'b1, 1'b1, 6, 1'b0, 1'b0);
    idle(7);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk); #1;
    check_all();
    rst_n = 1'b1;
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 25,
            1'($urandom()), 1'($urandom()),
            ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6)),
            $urandom_range(0, 99) < 12,
            $urandom_range(0, 99) < 3);
    end
    idle(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
